serial_op_ctrl: RTL and testbench

Sequencer for the bit-serial datapath. Accepts a word-wide operation (two operands plus opcode) over a valid/ready handshake, loads the operands into internal right-shifting operand registers, and steps them LSB-first through a 1-bit ALU slice with a carry flip-flop. It shifts result bits into a result register from the MSB end and presents the finished word over a second valid/ready handshake. It sits between the CPU control FSM and the serial execute stage and is the single owner of shift enable, load and direction for the operand and result registers.

---
 rtl/serial_op_ctrl.sv | 146 ++++++++++++++
 tb/tb_serial_op_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_op_ctrl.sv
// Bit-serial operation sequencer: accepts op/a/b, steps them LSB-first through a
// 1-bit ALU slice with carry, and presents the result word. Optional abort path: SOP_ABORT_EN.
module serial_op_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             busy,
`ifdef SOP_ABORT_EN
   input  logic             abort,
`endif
   output logic [1:0]       state_dbg
);

   // Handshakes: a transfer happens on a rising edge where valid && ready; valid
   // and its payload stay stable until that edge, ready never depends on valid.

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, res_q;
   logic [CW-1:0]    cnt_q;
   logic [2:0]       op_q;
   logic             carry_q;
   logic             load, shift_en, clr, abort_w;
   logic             b_eff, slice_bit, slice_cout, arith;

`ifdef SOP_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   // One-bit ALU slice working on the current LSBs and the carry flip-flop.
   always_comb begin
      arith      = (op_q == OP_ADD) || (op_q == OP_SUB);
      b_eff      = (op_q == OP_SUB) ? ~b_q[0] : b_q[0];
      slice_cout = (a_q[0] & b_eff) | (a_q[0] & carry_q) | (b_eff & carry_q);
      case (op_q)
         OP_ADD, OP_SUB: slice_bit = a_q[0] ^ b_eff ^ carry_q;
         OP_AND:         slice_bit = a_q[0] & b_q[0];
         OP_OR:          slice_bit = a_q[0] | b_q[0];
         OP_XOR:         slice_bit = a_q[0] ^ b_q[0];
         default:        slice_bit = a_q[0];
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      load      = 1'b0;
      shift_en  = 1'b0;
      clr       = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid && !abort_w) begin
               load    = 1'b1;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            busy = 1'b1;
            if (abort_w) begin
               clr     = 1'b1;
               state_d = S_IDLE;
            end else begin
               shift_en = 1'b1;
               if (cnt_q == CNT_LAST) state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            // Clearing on the handshake keeps result at zero whenever idle.
            if (abort_w || out_ready) begin
               clr     = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         op_q    <= '0;
         carry_q <= 1'b0;
      end else if (load) begin
         a_q     <= a;
         b_q     <= b;
         op_q    <= op;
         res_q   <= '0;
         cnt_q   <= '0;
         carry_q <= (op == OP_SUB);
      end else if (clr) begin
         res_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
      end else if (shift_en) begin
         a_q   <= {1'b0, a_q[WIDTH-1:1]};
         b_q   <= {1'b0, b_q[WIDTH-1:1]};
         res_q <= {slice_bit, res_q[WIDTH-1:1]};
         if (arith) carry_q <= slice_cout;
         if (cnt_q != CNT_LAST) cnt_q <= cnt_q + 1'b1;
      end
   end

   assign result    = res_q;
   assign carry_out = carry_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_op_ctrl.sv
// Scoreboard bench for serial_op_ctrl: randomized and directed operations checked
// against an arithmetic reference model; abort cases built with SOP_ABORT_EN.
module tb_serial_op_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rstn;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a, b;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             busy;
   logic [1:0]       state_dbg;
`ifdef SOP_ABORT_EN
   logic             abort;
`endif

   int cyc = 0;
   int n_cmp = 0;
   int n_err = 0;
   int rdy_mode = 0;
   int last_acc = 0;
   bit b2b = 1'b0;

   logic [WIDTH:0] exp_q[$];
   int             exp_t[$];

   serial_op_ctrl #(.WIDTH(WIDTH)) dut (
      .clk(clk),
      .rstn(rstn),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .op(op),
      .a(a),
      .b(b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result(result),
      .carry_out(carry_out),
      .busy(busy),
`ifdef SOP_ABORT_EN
      .abort(abort),
`endif
      .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   // Consumer: 0 = always ready, 1 = random, 2 = stalled.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ($urandom_range(0, 2) != 0);
         default: out_ready = 1'b0;
      endcase
   end

   // ---------------- reference model ----------------
   function automatic logic [WIDTH:0] ref_op(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      logic [WIDTH:0] r;
      case (o)
         3'd0: r = {1'b0, x} + {1'b0, y};
         3'd1: r = {(x >= y), x - y};
         3'd2: r = {1'b0, x & y};
         3'd3: r = {1'b0, x | y};
         3'd4: r = {1'b0, x ^ y};
         default: r = {1'b0, x};
      endcase
      return r;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail(input string nm);
      n_cmp++;
      n_err++;
      $display("FAIL %s: actual=timeout expected=event (cycle %0d)", nm, cyc);
   endtask

   // ---------------- driver tasks (called at posedge+1) ----------------
   task automatic send(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic [WIDTH:0] e);
      int t;
      t = 0;
      in_valid = 1'b1;
      op = o;
      a = x;
      b = y;
      @(negedge clk);
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) fail("accept_wait");
      else begin
         exp_q.push_back(e);
         exp_t.push_back(cyc + 1 + WIDTH);
         if (b2b) chk("b2b_interval", cyc + 1 - last_acc, WIDTH + 2);
         last_acc = cyc + 1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op = 3'($urandom);
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) fail("drain");
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid();
      int t;
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!out_valid) fail("out_valid_wait");
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_in_ready"}, in_ready, 1);
      chk({nm, "_out_valid"}, out_valid, 0);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_result"}, result, 0);
      chk({nm, "_carry"}, carry_out, 0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic             prev_v = 1'b0;
   logic             prev_rdy = 1'b0;
   logic [WIDTH-1:0] prev_r = '0;
   logic             prev_c = 1'b0;

   always @(negedge clk) begin
      logic [WIDTH:0] e;
      if (!rstn) begin
         prev_v = 1'b0;
      end else begin
         if (out_valid) begin
            if (!prev_v) begin
               if (exp_t.size() == 0) chk("unexpected_out_valid", 1, 0);
               else chk("latency", cyc, exp_t[0]);
            end else if (!prev_rdy) begin
               chk("hold_result", result, prev_r);
               chk("hold_carry", carry_out, prev_c);
            end
            if (out_ready) begin
               if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("result", result, e[WIDTH-1:0]);
                  chk("carry_out", carry_out, e[WIDTH]);
               end
               if (exp_t.size() != 0) void'(exp_t.pop_front());
            end
         end
         prev_v   = out_valid;
         prev_rdy = out_ready;
         prev_r   = result;
         prev_c   = carry_out;
      end
   end

   // ---------------- stimulus ----------------
   logic [2:0]       d_op[9] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
   logic [WIDTH-1:0] d_a[9]  = '{8'h5A, 8'hFF, 8'h10, 8'h00, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3};
   logic [WIDTH-1:0] d_b[9]  = '{8'h3C, 8'h01, 8'h01, 8'h01, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
   logic [WIDTH:0]   d_e[9]  = '{9'h096, 9'h100, 9'h10F, 9'h0FF, 9'h042, 9'h0DB, 9'h099, 9'h0C3, 9'h0C3};

   initial begin
      rstn = 1'b0;
      in_valid = 1'b0;
      op = '0;
      a = '0;
      b = '0;
`ifdef SOP_ABORT_EN
      abort = 1'b0;
`endif
      #1;
      chk_idle("reset");
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      chk_idle("post_reset");

      // Directed operations from the test plan
      foreach (d_op[i]) begin
         send(d_op[i], d_a[i], d_b[i], d_e[i]);
         drain();
      end

      // in_valid during SHIFT is ignored
      send(3'd0, 8'h12, 8'h34, 9'h046);
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         a = WIDTH'($urandom);
         b = WIDTH'($urandom);
         @(negedge clk);
         chk("shift_in_ready", in_ready, 0);
         chk("shift_busy", busy, 1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      drain();

      // Back-pressure: hold DONE for 5 cycles
      rdy_mode = 2;
      @(posedge clk);
      #1;
      send(3'd0, 8'h70, 8'h90, 9'h100);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("done_out_valid", out_valid, 1);
         chk("done_in_ready", in_ready, 0);
      end
      rdy_mode = 0;
      drain();

      // Back-to-back requests with in_valid held continuously
      send(3'd1, 8'h44, 8'h21, 9'h123);
      b2b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a = WIDTH'($urandom);
         b = WIDTH'($urandom);
         send(3'd0, a, b, ref_op(3'd0, a, b));
      end
      b2b = 1'b0;
      drain();

      // Asynchronous reset mid-SHIFT
      send(3'd0, 8'h33, 8'h44, 9'h077);
      repeat (2) @(posedge clk);
      #2;
      rstn = 1'b0;
      exp_q.delete();
      exp_t.delete();
      #1;
      chk_idle("mid_reset");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      send(3'd0, 8'h01, 8'h01, 9'h002);
      drain();

`ifdef SOP_ABORT_EN
      // Abort during SHIFT at bit 5
      send(3'd0, 8'h0F, 8'h01, 9'h010);
      repeat (4) @(posedge clk);
      #1;
      abort = 1'b1;
      exp_q.delete();
      exp_t.delete();
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk_idle("abort");
      for (int i = 0; i < WIDTH + 4; i++) begin
         @(negedge clk);
         chk("abort_no_valid", out_valid, 0);
      end
      @(posedge clk);
      #1;
      // Abort in IDLE blocks an accept
      abort = 1'b1;
      in_valid = 1'b1;
      op = 3'd0;
      @(posedge clk);
      #1;
      abort = 1'b0;
      in_valid = 1'b0;
      chk("abort_idle_busy", busy, 0);
      chk("abort_idle_in_ready", in_ready, 1);
      send(3'd4, 8'hF0, 8'h3C, 9'h0CC);
      drain();
`endif

      // Randomized operations with random consumer stalls
      rdy_mode = 1;
      for (int i = 0; i < 40; i++) begin
         logic [2:0]       ro;
         logic [WIDTH-1:0] ra, rb;
         ro = 3'($urandom_range(0, 7));
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         send(ro, ra, rb, ref_op(ro, ra, rb));
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
      end
      drain();
      rdy_mode = 0;
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
